msrh_l2_req_responder: RTL and testbench

// - L2-side slave of l2_req_if: accepts L1D write-backs (M_XWR) and line reads (M_XRD) from the L1D store/refill requestors.
// - Buffers requests in an in-order FIFO, drains them to a single-port backing-memory interface, returns read data on l2_resp_if.
// - Sits between the L1D request arbiter and the L2 data array / memory model.

---
 rtl/msrh_lsu_pkg.sv | 36 +++
 rtl/msrh_l2_req_fifo.sv | 44 ++++
 rtl/msrh_l2_req_responder.sv | 97 +++++++++
 tb/tb_msrh_l2_req_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrh_lsu_pkg.sv
// Shared LSU/L2 request types: command codes, request/response payloads,
// responder FSM states and a line-alignment helper.
package msrh_lsu_pkg;

  localparam int PADDR_W         = 32;
  localparam int DCACHE_DATA_B_W = 16;
  localparam int L2_CMD_TAG_W    = 4;
  localparam int LINE_DATA_W     = DCACHE_DATA_B_W * 8;

  typedef logic [1:0] l2_cmd_t;
  localparam l2_cmd_t M_XRD = 2'd0;
  localparam l2_cmd_t M_XWR = 2'd1;

  typedef struct packed {
    l2_cmd_t                    cmd;
    logic [PADDR_W-1:0]         addr;
    logic [L2_CMD_TAG_W-1:0]    tag;
    logic [LINE_DATA_W-1:0]     data;
    logic [DCACHE_DATA_B_W-1:0] byte_en;
  } l2_req_t;

  typedef struct packed {
    logic [L2_CMD_TAG_W-1:0] tag;
    logic [LINE_DATA_W-1:0]  data;
  } l2_resp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  localparam logic [PADDR_W-1:0] LINE_OFS_MASK = PADDR_W'(DCACHE_DATA_B_W - 1);

  // Clear the byte-within-line offset bits.
  function automatic logic [PADDR_W-1:0] line_align(input logic [PADDR_W-1:0] a);
    return a & ~LINE_OFS_MASK;
  endfunction

endpackage

// File: rtl/msrh_l2_req_fifo.sv
// In-order request FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate count.
module msrh_l2_req_fifo
  import msrh_lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  input  logic    i_push,
  input  l2_req_t i_data,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output l2_req_t o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_q, rd_ptr_q;
  l2_req_t     mem_q [DEPTH];

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign o_head  = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer advance on push/pop; cleared immediately by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/msrh_l2_req_responder.sv
// L2-side responder: queues L1D write-backs and line reads, runs them one
// at a time against the backing memory, and returns read lines in order.
module msrh_l2_req_responder
  import msrh_lsu_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int ADDR_W    = PADDR_W
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_l2_req_valid,
  output logic                       o_l2_req_ready,
  input  l2_req_t                    i_l2_req_payload,
  output logic                       o_l2_resp_valid,
  input  logic                       i_l2_resp_ready,
  output l2_resp_t                   o_l2_resp_payload,
  output logic                       o_mem_req_valid,
  input  logic                       i_mem_req_ready,
  output logic                       o_mem_we,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic [LINE_DATA_W-1:0]     o_mem_wdata,
  output logic [DCACHE_DATA_B_W-1:0] o_mem_be,
  input  logic                       i_mem_rd_valid,
  input  logic [LINE_DATA_W-1:0]     i_mem_rd_data
);

  state_t                 state_q;
  logic [LINE_DATA_W-1:0] rdata_q;

  logic    full, empty, push, pop, cmd_ok, head_wr;
  l2_req_t head, push_data;

  // Ready depends only on registered FIFO state, so a full FIFO that pops
  // this cycle still refuses the incoming request.
  assign o_l2_req_ready = !full;
  assign push           = i_l2_req_valid && !full;

  // Requests are stored already line-aligned.
  always_comb begin
    push_data      = i_l2_req_payload;
    push_data.addr = line_align(i_l2_req_payload.addr);
  end

  assign head_wr = (head.cmd == M_XWR);
  assign cmd_ok  = head_wr || (head.cmd == M_XRD);

  // Unknown commands are discarded at the head; writes retire on memory
  // accept (posted); reads retire when the response is taken.
  assign pop = (state_q == IDLE  && !empty && !cmd_ok) ||
               (state_q == ISSUE && i_mem_req_ready && head_wr) ||
               (state_q == RESP  && i_l2_resp_ready);

  msrh_l2_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push),
    .i_data    (push_data),
    .i_pop     (pop),
    .o_full    (full),
    .o_empty   (empty),
    .o_head    (head)
  );

  // Head-of-queue sequencer with captured read data; only WAIT_RD listens
  // to read returns, so stray ones (e.g. after reset) are dropped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (!empty && cmd_ok) state_q <= ISSUE;
        ISSUE:   if (i_mem_req_ready) state_q <= head_wr ? IDLE : WAIT_RD;
        WAIT_RD: if (i_mem_rd_valid) begin
                   rdata_q <= i_mem_rd_data;
                   state_q <= RESP;
                 end
        RESP:    if (i_l2_resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port: fields come straight from the held head entry, zero when idle.
  assign o_mem_req_valid = (state_q == ISSUE);
  assign o_mem_we        = o_mem_req_valid && head_wr;
  assign o_mem_addr      = o_mem_req_valid ? ADDR_W'(head.addr) : '0;
  assign o_mem_wdata     = o_mem_we ? head.data : '0;
  assign o_mem_be        = o_mem_we ? head.byte_en : '0;

  // Response: head and capture register do not move until the pop, so the
  // payload stays stable under backpressure.
  assign o_l2_resp_valid        = (state_q == RESP);
  assign o_l2_resp_payload.tag  = o_l2_resp_valid ? head.tag : '0;
  assign o_l2_resp_payload.data = o_l2_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_msrh_l2_req_responder.sv
// Randomized bench for msrh_l2_req_responder with a queue/array reference
// model and a behavioural backing memory.
module tb_msrh_l2_req_responder;
  import msrh_lsu_pkg::*;

  logic                       clk;
  logic                       i_reset_n;
  logic                       i_l2_req_valid;
  logic                       o_l2_req_ready;
  l2_req_t                    i_l2_req_payload;
  logic                       o_l2_resp_valid;
  logic                       i_l2_resp_ready;
  l2_resp_t                   o_l2_resp_payload;
  logic                       o_mem_req_valid;
  logic                       i_mem_req_ready;
  logic                       o_mem_we;
  logic [31:0]                o_mem_addr;
  logic [127:0]               o_mem_wdata;
  logic [15:0]                o_mem_be;
  logic                       i_mem_rd_valid;
  logic [127:0]               i_mem_rd_data;

  msrh_l2_req_responder #(.REQ_DEPTH(4), .ADDR_W(32)) dut (
    .i_clk             (clk),
    .i_reset_n         (i_reset_n),
    .i_l2_req_valid    (i_l2_req_valid),
    .o_l2_req_ready    (o_l2_req_ready),
    .i_l2_req_payload  (i_l2_req_payload),
    .o_l2_resp_valid   (o_l2_resp_valid),
    .i_l2_resp_ready   (i_l2_resp_ready),
    .o_l2_resp_payload (o_l2_resp_payload),
    .o_mem_req_valid   (o_mem_req_valid),
    .i_mem_req_ready   (i_mem_req_ready),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .o_mem_be          (o_mem_be),
    .i_mem_rd_valid    (i_mem_rd_valid),
    .i_mem_rd_data     (i_mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [127:0] data; logic [15:0] be; } memop_t;
  typedef struct { logic [3:0] tag; logic [127:0] data; } resp_t;

  memop_t       exp_mem[$];
  resp_t        exp_resp[$];
  logic [127:0] ref_mem   [logic [31:0]];
  logic [127:0] bench_mem [logic [31:0]];

  int nchk = 0, nerr = 0;
  int stall_cnt = 0;   // cycles the memory refuses requests
  int mem_rand  = 0;   // random memory ready when set
  int resp_mode = 0;   // 0: ready, 1: random, 2: held low
  int lat_fix   = 3;   // read latency, 0 = random 1..4
  int rd_cnt    = 0;
  logic [127:0] rd_buf;
  bit           resp_hold = 0;
  l2_resp_t     held;

  function automatic logic [127:0] dflt(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5a5a5a5a, a + 32'd1};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] w,
                                         input logic [15:0] be);
    logic [127:0] r = old;
    for (int b = 0; b < 16; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  // Reference model: what the memory and the response channel must see, in order.
  function automatic void model_push(input logic [1:0] cmd, input logic [31:0] addr,
                                     input logic [3:0] tag, input logic [127:0] data,
                                     input logic [15:0] be);
    logic [31:0]  line = addr & ~32'hF;
    logic [127:0] cur  = ref_mem.exists(line) ? ref_mem[line] : dflt(line);
    memop_t m;
    resp_t  r;
    if (cmd == M_XWR) begin
      m = '{we: 1'b1, addr: line, data: data, be: be};
      exp_mem.push_back(m);
      ref_mem[line] = merge(cur, data, be);
    end else if (cmd == M_XRD) begin
      m = '{we: 1'b0, addr: line, data: '0, be: '0};
      exp_mem.push_back(m);
      r = '{tag: tag, data: cur};
      exp_resp.push_back(r);
    end
  endfunction

  // Backing memory + response sink: choose this cycle's ready values, then
  // score any handshake that the next rising edge will complete.
  always @(negedge clk) begin
    logic mr, rr;
    logic [127:0] cur;
    memop_t e;
    resp_t  er;
    i_mem_rd_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin i_mem_rd_valid = 1'b1; i_mem_rd_data = rd_buf; end
    end
    if (stall_cnt > 0) begin stall_cnt--; mr = 1'b0; end
    else mr = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    i_mem_req_ready = mr;
    if (o_mem_req_valid && mr) begin
      nchk++;
      if (exp_mem.size() == 0) begin
        nerr++;
        $display("FAIL mem_unexpected: got we=%0b addr=%h, want no access", o_mem_we, o_mem_addr);
      end else begin
        e = exp_mem.pop_front();
        if (o_mem_we !== e.we || o_mem_addr !== e.addr ||
            (e.we && (o_mem_wdata !== e.data || o_mem_be !== e.be))) begin
          nerr++;
          $display("FAIL mem_op: got we=%0b addr=%h data=%h be=%h, want we=%0b addr=%h data=%h be=%h",
                   o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, e.we, e.addr, e.data, e.be);
        end
      end
      cur = bench_mem.exists(o_mem_addr) ? bench_mem[o_mem_addr] : dflt(o_mem_addr);
      if (o_mem_we) bench_mem[o_mem_addr] = merge(cur, o_mem_wdata, o_mem_be);
      else begin
        rd_buf = cur;
        rd_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
      end
    end
    rr = (resp_mode == 0) ? 1'b1 : (resp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    i_l2_resp_ready = rr;
    if (!i_reset_n) resp_hold = 0;
    else if (o_l2_resp_valid) begin
      if (resp_hold) begin
        nchk++;
        if (o_l2_resp_payload !== held) begin
          nerr++;
          $display("FAIL resp_stable: got %h, want %h", o_l2_resp_payload, held);
        end
      end
      if (rr) begin
        resp_hold = 0;
        nchk++;
        if (exp_resp.size() == 0) begin
          nerr++;
          $display("FAIL resp_unexpected: got tag=%h data=%h, want none",
                   o_l2_resp_payload.tag, o_l2_resp_payload.data);
        end else begin
          er = exp_resp.pop_front();
          if (o_l2_resp_payload.tag !== er.tag || o_l2_resp_payload.data !== er.data) begin
            nerr++;
            $display("FAIL resp: got tag=%h data=%h, want tag=%h data=%h",
                     o_l2_resp_payload.tag, o_l2_resp_payload.data, er.tag, er.data);
          end
        end
      end else begin
        resp_hold = 1;
        held = o_l2_resp_payload;
      end
    end else begin
      if (resp_hold) begin
        nchk++; nerr++;
        $display("FAIL resp_valid_drop: got valid=0, want 1 until ready");
      end
      resp_hold = 0;
    end
  end

  task automatic push(input logic [1:0] cmd, input logic [31:0] addr, input logic [3:0] tag,
                      input logic [127:0] data, input logic [15:0] be);
    bit acc = 0;
    i_l2_req_valid   = 1'b1;
    i_l2_req_payload = '{cmd: cmd, addr: addr, tag: tag, data: data, byte_en: be};
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (o_l2_req_ready) begin acc = 1; model_push(cmd, addr, tag, data, be); end
      @(posedge clk); #1;
    end
    i_l2_req_valid = 1'b0;
    if (!acc) begin nchk++; nerr++; $display("FAIL push_timeout: got no accept, want accept"); end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_mem.size() == 0 && exp_resp.size() == 0 && !o_mem_req_valid && !o_l2_resp_valid)
        done = 1;
    end
    nchk++;
    if (!done) begin
      nerr++;
      $display("FAIL drain: got %0d mem / %0d resp pending, want 0", exp_mem.size(), exp_resp.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_idle_outputs(input string nm);
    nchk++;
    if (o_l2_req_ready !== 1'b1 || o_l2_resp_valid !== 1'b0 || o_mem_req_valid !== 1'b0 ||
        o_mem_we !== 1'b0 || o_mem_addr !== 32'h0 || o_mem_wdata !== 128'h0 ||
        o_mem_be !== 16'h0 || o_l2_resp_payload !== '0) begin
      nerr++;
      $display("FAIL %s: got rdy=%0b rv=%0b mv=%0b we=%0b addr=%h be=%h, want rdy=1 others 0",
               nm, o_l2_req_ready, o_l2_resp_valid, o_mem_req_valid, o_mem_we, o_mem_addr, o_mem_be);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); check_idle_outputs("reset_in");
    @(posedge clk); #1; i_reset_n = 1'b1;
    @(negedge clk); check_idle_outputs("reset_out");
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int lat = 0;
    mem_rand = 0;
    push(M_XWR, 32'h8000_0040, 4'h1, rnd128(), 16'hFFFF);
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (o_mem_req_valid) lat = i;
    end
    nchk++;
    if (lat != 2) begin
      nerr++;
      $display("FAIL write_latency: got valid at sample %0d after push, want sample 2", lat);
    end
    @(posedge clk); #1;
    wait_drain(20);
  endtask

  task automatic test_raw();
    lat_fix = 3;
    push(M_XWR, 32'h8000_0100, 4'h2, rnd128(), 16'hFFFF);
    push(M_XRD, 32'h8000_0100, 4'h5, '0, '0);
    push(M_XWR, 32'h8000_0100, 4'h3, rnd128(), 16'h00F0);
    push(M_XRD, 32'h8000_0108, 4'hA, '0, '0);
    wait_drain(60);
  endtask

  task automatic test_backpressure();
    stall_cnt = 10;
    for (int i = 0; i < 4; i++) push(M_XWR, 32'h8000_0200 + 32'(i * 16), 4'(i), rnd128(), 16'hFFFF);
    @(negedge clk);
    nchk++;
    if (o_l2_req_ready !== 1'b0) begin
      nerr++; $display("FAIL full_ready: got %0b, want 0", o_l2_req_ready);
    end
    @(posedge clk); #1;
    push(M_XRD, 32'h8000_0210, 4'h4, '0, '0);
    push(M_XWR, 32'h8000_0250, 4'h5, rnd128(), 16'h0F0F);
    wait_drain(80);
  endtask

  task automatic test_resp_hold();
    bit seen = 0;
    resp_mode = 2;
    push(M_XRD, 32'h8000_0300, 4'h9, '0, '0);
    push(M_XWR, 32'h8000_0340, 4'h7, rnd128(), 16'hFFFF);
    for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = o_l2_resp_valid; end
    for (int i = 0; i < 5; i++) begin
      nchk++;
      if (o_l2_resp_valid !== 1'b1 || o_mem_req_valid !== 1'b0) begin
        nerr++;
        $display("FAIL resp_hold: got rv=%0b mv=%0b, want rv=1 mv=0", o_l2_resp_valid, o_mem_req_valid);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_mode = 0;
    wait_drain(40);
  endtask

  task automatic test_align();
    bit seen = 0;
    push(M_XWR, 32'h8000_0047, 4'h6, rnd128(), 16'h000F);
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = o_mem_req_valid; end
    nchk++;
    if (!seen || o_mem_addr !== 32'h8000_0040 || o_mem_be !== 16'h000F) begin
      nerr++;
      $display("FAIL align: got addr=%h be=%h, want addr=80000040 be=000f", o_mem_addr, o_mem_be);
    end
    @(posedge clk); #1;
    wait_drain(20);
  endtask

  task automatic test_bad_cmd();
    push(2'd3, 32'h8000_0400, 4'hE, rnd128(), 16'hFFFF);
    push(M_XRD, 32'h8000_0400, 4'hD, '0, '0);
    wait_drain(30);
  endtask

  task automatic test_reset_mid();
    lat_fix = 6;
    push(M_XRD, 32'h8000_0500, 4'hC, '0, '0);
    for (int i = 0; i < 20 && exp_mem.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    i_reset_n = 1'b0;
    exp_mem.delete();
    exp_resp.delete();
    @(posedge clk); @(posedge clk); #1;
    i_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle_outputs("reset_mid");
    end
    @(posedge clk); #1;
    lat_fix = 3;
  endtask

  task automatic test_random();
    logic [1:0] cmd;
    mem_rand = 1; resp_mode = 1; lat_fix = 0;
    for (int i = 0; i < 40; i++) begin
      cmd = ($urandom_range(0, 1) == 1) ? M_XWR : M_XRD;
      push(cmd, 32'h8000_0600 + 32'($urandom_range(0, 63)), 4'($urandom),
           rnd128(), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_drain(600);
    mem_rand = 0; resp_mode = 0; lat_fix = 3;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_l2_req_valid = 1'b0;
    i_l2_req_payload = '0;
    i_l2_resp_ready = 1'b1;
    i_mem_req_ready = 1'b1;
    i_mem_rd_valid = 1'b0;
    i_mem_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_raw();
    test_backpressure();
    test_resp_hold();
    test_align();
    test_bad_cmd();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
